pulse_sched: RTL
================

PULSE_SCHED -- requirements
Module: pulse_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of level-request channels (range 2..8).
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the width of each per-channel pending counter (max 2^CNT_W-1).
REQ-003 The block SHALL have parameter GAP_CYC, default 2, giving the idle guard cycles after each pulse (range 0..15).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_en  input  1  grant enable; when low, no new pulse is issued.
REQ-008 i_lvl_req  input  N_REQ  per-channel level requests; each rising edge is one pulse request.
REQ-009 i_ovf_clr  input  1  clears all o_ovf bits.
REQ-010 o_pulse  output  N_REQ  one-hot, high for exactly 1 cycle per granted request.
REQ-011 o_busy  output  1  high while the scheduler is not in IDLE.
REQ-012 o_pend  output  N_REQ  bit i high while pending count i is nonzero.
REQ-013 o_ovf  output  N_REQ  sticky; bit i set when a channel-i request is dropped.

Function
REQ-014 Each channel SHALL have a 2-bit shift register sampling i_lvl_req[i] every cycle; edge_i is true while newest=1 and older=0.
REQ-015 While edge_i is true, pending count i SHALL increment at the next edge.
REQ-016 If count i = max and edge_i is true with no decrement, count i SHALL hold and o_ovf[i] SHALL set.
REQ-017 If increment and decrement of count i coincide, count i SHALL be unchanged and no overflow SHALL be flagged.
REQ-018 The FSM SHALL have states IDLE, ISSUE and GAP.
REQ-019 IDLE->ISSUE SHALL occur when i_en=1 and any count is nonzero.
REQ-020 On the IDLE->ISSUE edge, the winner SHALL be the first nonzero channel searching upward from ptr+1 (mod N_REQ); its count SHALL decrement and ptr SHALL take the winner index.
REQ-021 o_pulse SHALL be registered and equal onehot(winner) exactly while in ISSUE, otherwise zero.
REQ-022 ISSUE SHALL last 1 cycle, then go to GAP if GAP_CYC>0, else to IDLE.
REQ-023 GAP SHALL last exactly GAP_CYC cycles, then go to IDLE, regardless of i_en.
REQ-024 Consecutive pulses SHALL be separated by at least GAP_CYC+1 low cycles (pulse period >= GAP_CYC+2).
REQ-025 i_en=0 SHALL block only IDLE->ISSUE; edge capture and counting SHALL continue.
REQ-026 Latency SHALL be as follows: if i_lvl_req[i] is sampled 0 at edge k-1 and 1 at edge k, with the FSM idle, i_en=1 and no other pending, o_pulse[i] is high for the cycle following edge k+2.
REQ-027 A level held high SHALL produce one request only; the next request needs a low sample followed by a high sample.
REQ-028 Simultaneous edges on multiple channels SHALL each increment their own count in the same cycle.
REQ-029 o_busy SHALL equal (state != IDLE).
REQ-030 o_pend[i] SHALL equal (count i != 0).
REQ-031 o_ovf[i] SHALL clear on i_ovf_clr=1, except a set in the same cycle, which wins.

Reset
REQ-032 While i_rst=1 at an edge, the following SHALL apply: state=IDLE, ptr=N_REQ-1 (channel 0 is first priority), all counts 0, all edge stages 0, o_pulse=0, o_busy=0, o_pend=0, o_ovf=0.
REQ-033 Reset asserted mid-ISSUE or mid-GAP SHALL drop o_pulse and o_busy at that edge and discard all pending requests.
REQ-034 A level high at reset release SHALL be detected as a new edge (stages reset to 0).

Verification
REQ-035 The bench SHALL cover: single request; N_REQ=4, GAP_CYC=2, i_lvl_req[2] rises at edge 10 -> o_pulse=4'b0100 during cycle after edge 12 only; o_busy high for 3 cycles.
REQ-036 The bench SHALL cover: all four channels rise at the same edge -> pulses ordered ch0, ch1, ch2, ch3, 4 cycles apart; o_pend clears per channel as each pulse is granted.
REQ-037 The bench SHALL cover overflow: with i_en=0 and CNT_W=3, 8 edges on ch1 -> count=7, o_ovf[1]=1; then i_en=1 -> exactly 7 pulses on ch1; i_ovf_clr -> o_ovf=0.
REQ-038 The bench SHALL cover round-robin fairness: ch0 and ch3 re-request continuously -> grants alternate ch0, ch3, ch0, ...; ch0 is never granted twice consecutively.
REQ-039 The bench SHALL cover: i_rst during GAP with 3 pending on ch2 -> o_busy=0, o_pend=0 next cycle; ch0 held high through reset -> one pulse on ch0 after release.
REQ-040 The bench SHALL cover GAP_CYC=0: back-to-back pending requests -> pulse period of 2 cycles.

Source files
------------

// File: rtl/pulse_sched.sv
// Level-to-pulse scheduler: counts rising edges per channel and issues
// round-robin single-cycle pulses separated by a guard gap.
module pulse_sched #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 3,
  parameter int GAP_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_lvl_req,
  input  logic             i_ovf_clr,
  output logic [N_REQ-1:0] o_pulse,
  output logic             o_busy,
  output logic [N_REQ-1:0] o_pend,
  output logic [N_REQ-1:0] o_ovf
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [3:0] GAP_LD =
    4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] stg0, stg1, edg;
  logic [N_REQ-1:0] dec, ovf_set, pulse_d;
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [PW-1:0]    ptr, win;
  logic [3:0]       gap_cnt;
  logic             any, go;

  assign edg = stg0 & ~stg1;
  assign go  = (state == IDLE) && i_en && any;

  // first nonzero channel searching upward from ptr+1
  always_comb begin
    int idx;
    idx = 0;
    win = ptr;
    any = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && cnt[PW'(idx)] != '0) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
  end

  always_comb begin
    dec     = '0;
    ovf_set = '0;
    o_pend  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      dec[i]     = go && (win == PW'(i));
      ovf_set[i] = edg[i] && !dec[i] && (&cnt[i]);
      o_pend[i]  = (cnt[i] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = ISSUE;
      ISSUE:   state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (state != IDLE);
    pulse_d = '0;
    if (go) pulse_d[win] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stg0    <= '0;
      stg1    <= '0;
      ptr     <= PW'(N_REQ - 1);
      gap_cnt <= '0;
      o_pulse <= '0;
      o_ovf   <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      stg0    <= i_lvl_req;
      stg1    <= stg0;
      o_pulse <= pulse_d;
      if (go) ptr <= win;
      if (state == ISSUE)      gap_cnt <= GAP_LD;
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
      // a set in the same cycle beats the clear
      o_ovf <= ovf_set | (o_ovf & ~{N_REQ{i_ovf_clr}});
      for (int i = 0; i < N_REQ; i++) begin
        if (edg[i] && !dec[i] && !(&cnt[i]))
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !edg[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule
